pong_game_ctrl: RTL

- Top-level game-state controller for Pong. Sits directly downstream of the countdown timer: consumes its `timer_up` flag and drives its `timer_start` reload strobe.
- Sequences new-game / play / new-ball / game-over, keeps the remaining-ball count and a two-digit BCD score, and freezes graphics between rallies.
- Outputs feed the graphics and text overlay units.

---
 rtl/pong_game_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: new-game / play / new-ball / game-over sequencing,
// ball count, two-digit BCD score and graphics freeze between rallies.
module pong_game_ctrl #(
    parameter int unsigned BALLS  = 3,
    parameter int unsigned BALL_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        btn,
    input  logic              hit,
    input  logic              miss,
    input  logic              timer_up,
    output logic              timer_start,
    output logic              gra_still,
    output logic [1:0]        game_state,
    output logic [BALL_W-1:0] balls_left,
    output logic [3:0]        dig1,
    output logic [3:0]        dig0
);

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    localparam logic [BALL_W-1:0] BALLS_FULL = BALL_W'(BALLS);
    localparam logic [BALL_W-1:0] BALLS_GAME = BALL_W'(BALLS - 1);

    state_t            state, state_next;
    logic [BALL_W-1:0] balls_next;
    logic [3:0]        dig1_next, dig0_next;
    logic              pressed;

    assign pressed    = |btn;
    assign game_state = state;

    // State, ball count and score registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_NEWGAME;
            balls_left <= BALLS_FULL;
            dig1       <= 4'd0;
            dig0       <= 4'd0;
        end else begin
            state      <= state_next;
            balls_left <= balls_next;
            dig1       <= dig1_next;
            dig0       <= dig0_next;
        end
    end

    // Next-state, score update and decoded outputs
    always_comb begin
        state_next  = state;
        balls_next  = balls_left;
        dig1_next   = dig1;
        dig0_next   = dig0;
        timer_start = 1'b0;
        gra_still   = 1'b1;
        case (state)
            ST_NEWGAME: begin
                // Score is left alone so the previous game's result stays visible
                balls_next = BALLS_FULL;
                if (pressed) begin
                    state_next = ST_PLAY;
                    balls_next = BALLS_GAME;
                    dig1_next  = 4'd0;
                    dig0_next  = 4'd0;
                end
            end
            ST_PLAY: begin
                gra_still = 1'b0;
                if (miss) begin
                    // Miss wins over a simultaneous hit
                    timer_start = 1'b1;
                    if (balls_left != '0) begin
                        state_next = ST_NEWBALL;
                        balls_next = BALL_W'(balls_left - BALL_W'(1));
                    end else begin
                        state_next = ST_OVER;
                    end
                end else if (hit) begin
                    if (dig0 == 4'd9) begin
                        dig0_next = 4'd0;
                        dig1_next = (dig1 == 4'd9) ? 4'd0 : 4'(dig1 + 4'd1);
                    end else begin
                        dig0_next = 4'(dig0 + 4'd1);
                    end
                end
            end
            ST_NEWBALL: begin
                if (timer_up && pressed) begin
                    state_next = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (timer_up) begin
                    state_next = ST_NEWGAME;
                    balls_next = BALLS_FULL;
                end
            end
            default: begin
                state_next = ST_NEWGAME;
            end
        endcase
    end

endmodule
